// File: rtl/clk_div_pkg.sv
// Shared defaults, channel-mode encoding and the channel-index width helper
// used by the clock divider bank.
package clk_div_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_CNT_W   = 26;
    localparam int DEF_DEF_DIV = 50000000;
    localparam int MIN_DIV     = 2;

    // What a channel does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        CH_SYNC = 2'd0,
        CH_HOLD = 2'd1,
        CH_RUN  = 2'd2
    } chan_mode_e;

    function automatic int ch_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor pair and
// registered square-wave / tick outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DEF_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] dact_q, dact_d;
    logic [CNT_W-1:0] dpend_q, dpend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] hi_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             wrap_s;
    logic             apply_s;
    chan_mode_e       mode_s;

    // Classify the coming edge and decide whether the pending divisor lands.
    always_comb begin
        hi_s      = dact_q - (dact_q >> 1);
        cnt_inc_s = cnt_q + ONE;
        wrap_s    = (cnt_q >= (dact_q - ONE));
        if (sync_i) begin
            mode_s = CH_SYNC;
        end else if (!en_i || (dact_q < MIN_D)) begin
            mode_s = CH_HOLD;
        end else begin
            mode_s = CH_RUN;
        end
        case (mode_s)
            CH_SYNC: apply_s = pend_q;
            CH_HOLD: apply_s = pend_q;
            CH_RUN:  apply_s = pend_q & wrap_s;
            default: apply_s = 1'b0;
        endcase
    end

    // Next-state: a new divisor only takes effect where a period starts, so
    // held/synced channels prime cnt to D-1 for an immediate rise.
    always_comb begin
        dact_d  = apply_s ? dpend_q : dact_q;
        dpend_d = wr_i ? wr_div_i : dpend_q;
        pend_d  = wr_i | (pend_q & ~apply_s);
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        tick_d  = 1'b0;
        case (mode_s)
            CH_SYNC, CH_HOLD: begin
                cnt_d = dact_d - ONE;
            end
            CH_RUN: begin
                if (wrap_s) begin
                    cnt_d  = {CNT_W{1'b0}};
                    out_d  = 1'b1;
                    tick_d = 1'b1;
                end else begin
                    cnt_d  = cnt_inc_s;
                    out_d  = (cnt_inc_s < hi_s);
                    tick_d = 1'b0;
                end
            end
            default: begin
                cnt_d = dact_q - ONE;
            end
        endcase
    end

    // Channel state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dact_q  <= DEF_D;
            dpend_q <= DEF_D;
            cnt_q   <= DEF_D - ONE;
            pend_q  <= 1'b0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            dact_q  <= dact_d;
            dpend_q <= dpend_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out_o = out_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers sharing one configuration port and
// a global phase-align sync.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DEF_DIV,
    parameter int CH_W    = ch_w(NCH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   en_i,
    input  logic             sync_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic [NCH-1:0]   clk_out_o,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   pend_o
);

    logic [NCH-1:0] sel_s;
    logic [NCH-1:0] wr_s;
    logic [NCH-1:0] pend_s;
    logic           ready_s;

    // An out-of-range channel selects nothing, so it reads ready and the
    // write is simply dropped.
    always_comb begin
        ready_s = ~|(sel_s & pend_s);
        wr_s    = sel_s & {NCH{cfg_valid_i & ready_s}};
    end

    for (genvar g = 0; g < NCH; g++) begin : gen_ch
        assign sel_s[g] = (cfg_ch_i == CH_W'(g));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i[g]),
            .sync_i    (sync_i),
            .wr_i      (wr_s[g]),
            .wr_div_i  (cfg_div_i),
            .clk_out_o (clk_out_o[g]),
            .tick_o    (tick_o[g]),
            .pend_o    (pend_s[g])
        );
    end

    assign cfg_ready_o = ready_s;
    assign pend_o      = pend_s;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: table-driven start-up vectors plus
// scoreboarded hand sequences for divisor changes, sync, parking and reset.
module tb_clk_div_bank;

    localparam int NCH     = 3;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 10;
    localparam int CH_W    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pend;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] out;
        logic [2:0] tk;
        logic [2:0] pd;
        logic       rdy;
        string      nm;
    } exp_t;

    typedef struct {
        logic [2:0] en;
        logic [2:0] out;
        logic [2:0] tk;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[22];

    clk_div_bank #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .sync_i      (sync),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_ch_i    (cfg_ch),
        .cfg_div_i   (cfg_div),
        .clk_out_o   (clk_out),
        .tick_o      (tick),
        .pend_o      (pend)
    );

    always #5 clk = ~clk;

    function automatic logic pat(int d, int j);
        return (j % d) < (d - d / 2);
    endfunction

    function automatic logic tkp(int d, int j);
        return (j % d) == 0;
    endfunction

    function automatic logic rdy_of(logic [2:0] pd);
        logic [3:0] ext;
        ext = {1'b0, pd};
        return (cfg_ch == 2'd3) ? 1'b1 : ~ext[cfg_ch];
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push(logic [2:0] out, logic [2:0] tk, logic [2:0] pd, string nm);
        exp_t e;
        e.out = out;
        e.tk  = tk;
        e.pd  = pd;
        e.rdy = rdy_of(pd);
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            chk({e.nm, "_out"},  {29'd0, clk_out}, {29'd0, e.out});
            chk({e.nm, "_tick"}, {29'd0, tick},    {29'd0, e.tk});
            chk({e.nm, "_pend"}, {29'd0, pend},    {29'd0, e.pd});
            chk({e.nm, "_rdy"},  {31'd0, cfg_ready}, {31'd0, e.rdy});
        end
    endtask

    task automatic wr(int ch, int d);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(d);
    endtask

    initial begin
        for (int j = 0; j < 22; j++) begin
            tbl[j].en  = (j < 20) ? 3'b001 : 3'b000;
            tbl[j].out = (j < 20) ? {2'b00, pat(DEF_DIV, j)} : 3'b000;
            tbl[j].tk  = (j < 20) ? {2'b00, tkp(DEF_DIV, j)} : 3'b000;
        end

        rst = 1'b1; en = 3'b000; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",  {29'd0, clk_out}, 32'd0);
        chk("rst_tick", {29'd0, tick}, 32'd0);
        chk("rst_pend", {29'd0, pend}, 32'd0);
        chk("rst_rdy",  {31'd0, cfg_ready}, 32'd1);
        rst = 1'b0;

        // Default divisor after reset, then disable.
        for (int j = 0; j < 22; j++) begin
            en = tbl[j].en;
            push(tbl[j].out, tbl[j].tk, 3'b000, "t1_def");
            step();
        end

        // D=3 and D=2 programmed while disabled.
        wr(1, 3);
        chk("t2_rdy_pre", {31'd0, cfg_ready}, 32'd1);
        push(3'b000, 3'b000, 3'b010, "t2_acc3");
        step();
        cfg_valid = 1'b0;
        push(3'b000, 3'b000, 3'b000, "t2_app3");
        step();
        en = 3'b010;
        for (int j = 0; j < 6; j++) begin
            push({1'b0, pat(3, j), 1'b0}, {1'b0, tkp(3, j), 1'b0}, 3'b000, "t2_d3");
            step();
        end
        en = 3'b000;
        wr(1, 2);
        push(3'b000, 3'b000, 3'b010, "t2_acc2");
        step();
        cfg_valid = 1'b0;
        push(3'b000, 3'b000, 3'b000, "t2_app2");
        step();
        en = 3'b010;
        for (int j = 0; j < 6; j++) begin
            push({1'b0, pat(2, j), 1'b0}, {1'b0, tkp(2, j), 1'b0}, 3'b000, "t2_d2");
            step();
        end

        // Running at D=8, change to D=4 mid-period.
        en = 3'b000;
        wr(2, 8);
        push(3'b000, 3'b000, 3'b100, "t3_acc8");
        step();
        cfg_valid = 1'b0;
        push(3'b000, 3'b000, 3'b000, "t3_app8");
        step();
        en = 3'b100;
        for (int j = 0; j < 16; j++) begin
            logic o, t, p;
            if (j == 3) begin
                wr(2, 4);
                chk("t3_rdy_pre", {31'd0, cfg_ready}, 32'd1);
            end
            o = (j < 8) ? pat(8, j) : pat(4, j - 8);
            t = (j < 8) ? tkp(8, j) : tkp(4, j - 8);
            p = (j >= 3) && (j < 8);
            push({o, 2'b00}, {t, 2'b00}, {p, 2'b00}, "t3_chg");
            step();
            cfg_valid = 1'b0;
        end

        // Skewed D=6 / D=9 channels, then sync aligns them.
        en = 3'b000;
        wr(0, 6);
        push(3'b000, 3'b000, 3'b001, "t4_acc6");
        step();
        wr(2, 9);
        push(3'b000, 3'b000, 3'b100, "t4_acc9");
        step();
        cfg_valid = 1'b0;
        push(3'b000, 3'b000, 3'b000, "t4_app9");
        step();
        en = 3'b001;
        push(3'b001, 3'b001, 3'b000, "t4_sk0");
        step();
        push(3'b001, 3'b000, 3'b000, "t4_sk1");
        step();
        en = 3'b101;
        push(3'b101, 3'b100, 3'b000, "t4_sk2");
        step();
        push(3'b100, 3'b000, 3'b000, "t4_sk3");
        step();
        push(3'b100, 3'b000, 3'b000, "t4_sk4");
        step();
        sync = 1'b1;
        push(3'b000, 3'b000, 3'b000, "t4_sync");
        step();
        sync = 1'b0;
        for (int f = 0; f < 18; f++) begin
            push({pat(9, f), 1'b0, pat(6, f)}, {tkp(9, f), 1'b0, tkp(6, f)}, 3'b000, "t4_align");
            step();
        end

        // Parked at D=0, then D=5; an out-of-range write changes nothing.
        en = 3'b000;
        wr(1, 0);
        push(3'b000, 3'b000, 3'b010, "t5_acc0");
        step();
        cfg_valid = 1'b0;
        push(3'b000, 3'b000, 3'b000, "t5_app0");
        step();
        en = 3'b010;
        for (int j = 0; j < 4; j++) begin
            push(3'b000, 3'b000, 3'b000, "t5_park");
            step();
        end
        wr(1, 5);
        chk("t5_rdy_pre", {31'd0, cfg_ready}, 32'd1);
        push(3'b000, 3'b000, 3'b010, "t5_acc5");
        step();
        cfg_valid = 1'b0;
        push(3'b000, 3'b000, 3'b000, "t5_app5");
        step();
        for (int j = 0; j < 16; j++) begin
            if (j == 7) begin
                wr(3, 2);
                chk("t5_inv_rdy", {31'd0, cfg_ready}, 32'd1);
            end
            push({1'b0, pat(5, j), 1'b0}, {1'b0, tkp(5, j), 1'b0}, 3'b000, "t5_d5");
            step();
            cfg_valid = 1'b0;
        end

        // Reset during the high phase with a write pending.
        wr(1, 7);
        chk("t6_rdy_pre", {31'd0, cfg_ready}, 32'd1);
        push({1'b0, pat(5, 16), 1'b0}, 3'b000, 3'b010, "t6_pre");
        step();
        cfg_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_out",  {29'd0, clk_out}, 32'd0);
        chk("t6_async_tick", {29'd0, tick}, 32'd0);
        chk("t6_async_pend", {29'd0, pend}, 32'd0);
        chk("t6_async_rdy",  {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            push({1'b0, pat(DEF_DIV, j), 1'b0}, {1'b0, tkp(DEF_DIV, j), 1'b0}, 3'b000, "t6_def");
            step();
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent clock-enable/square-wave dividers, each with a runtime-programmable divisor. It generates slow strobes and derived square waves (LED blink, display scan, baud-ish ticks) from the single system clock. Divisor changes apply glitch-free at the channel's next period boundary. A global sync restarts all channels phase-aligned.

## Interface
- NCH, 4: number of divider channels (1..16)
- CNT_W, 26: divisor/counter width in bits
- DEF_DIV, 50000000: divisor loaded into every channel at reset (must be < 2^CNT_W)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  NCH  per-channel run enable
- sync  in  1  one-cycle pulse: restart all channels phase-aligned
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write accepted this cycle when cfg_valid & cfg_ready
- cfg_ch  in  CH_W = max(1, clog2(NCH))  target channel
- cfg_div  in  CNT_W  new divisor D
- clk_out  out  NCH  divided square wave, registered
- tick  out  NCH  one-cycle pulse coincident with each rising edge of clk_out
- pend  out  NCH  channel holds an accepted, not-yet-applied divisor

## Operation
- Per channel: active divisor D_act, pending divisor D_pend, pending flag pend, counter cnt (CNT_W bits).
- HI = D_act - floor(D_act/2); output high for HI cycles, low for floor(D_act/2) cycles; period = D_act cycles.
- Edge with en=1, D_act >= 2:
  - cnt == D_act-1: cnt<=0, clk_out<=1, tick<=1; if pend then D_act<=D_pend, pend<=0.
  - Otherwise: cnt<=cnt+1, clk_out<=(cnt+1 < HI), tick<=0.
- D_act < 2 (0 or 1): channel parked, clk_out=0, tick=0; pending divisor applied on next edge.
- en=0: clk_out<=0, tick<=0, cnt<=D_act-1 (primes immediate rise on re-enable); pending divisor applied on next edge.
- cfg_ready = ~pend[cfg_ch] (combinational). Accepted write sets D_pend<=cfg_div, pend<=1. Write with cfg_ready=0 is ignored; master must hold request.
- cfg_ch >= NCH: cfg_ready=1, write accepted and discarded.
- sync=1: every channel applies any pending divisor, cnt<=D_new-1, clk_out<=0, tick<=0. Next enabled edge is a common rising edge on all channels.
- Simultaneous events on one edge:
  - sync + accepted write: write lands in D_pend, applied at next wrap.
  - Wrap + accepted write to same channel: cannot occur (cfg_ready low while pend); for pend=0 the write becomes pending and the wrap keeps old D_act.
- Arithmetic is unsigned, CNT_W bits; no wrap beyond D_act-1.

## Timing
- Reset values: D_act=DEF_DIV, D_pend=DEF_DIV, pend=0, cnt=DEF_DIV-1, clk_out=0, tick=0; cfg_ready=1.
- Reset mid-period: outputs drop to 0 asynchronously; pending writes are lost.
- Enable latency: first edge with en=1 raises clk_out and tick (1 cycle).
- Divisor change latency: at most D_old cycles after acceptance (next wrap); cycle-exact at the boundary, no runt pulses.
- pend falls on the same edge that applies D_pend; cfg_ready for that channel returns the same cycle.

## Structure
- Package clk_div_pkg: defaults NCH, CNT_W, DEF_DIV; CH_W function; MIN_DIV=2 constant.
- Sub-module clk_div_chan: one channel (counter, D_act/D_pend, pend, outputs). Top instantiates NCH copies and handles cfg decode, cfg_ready mux and sync fan-out.

## Test plan
- Reset, DEF_DIV=10, en=1 -> clk_out 5 high/5 low repeating; tick every 10 cycles, first on edge 1 after enable.
- D=3 written while en=0, then en=1 -> pattern 1,1,0 repeating; D=2 -> 1,0 alternating.
- Running at D=8, write D=4 mid-period -> pend=1 and cfg_ready=0 until wrap; old 8-cycle period completes, then 4-cycle period; no short pulse.
- Channels at D=6 and D=9, skewed, assert sync -> next edge both tick together.
- Write D=0 -> clk_out stays 0; write D=5 -> applied next edge, runs normally; cfg_ch=NCH write -> no channel changes.
- Assert rst mid-high-phase -> clk_out 0 immediately; after release, pend=0, DEF_DIV period restored.
